fp_mult_sequencer: RTL and testbench
====================================

FP_MULT_SEQUENCER -- requirements
Module: fp_mult_sequencer

Interface
REQ-001 Parameters SHALL be: ROM_DEPTH, 5, number of operand words; MULT_LATENCY, 3, cycles from operands stable at multiplier inputs to product valid.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 op_a  output  32  operand A to sp_fp_multiplier, registered.
REQ-007 op_b  output  32  operand B to sp_fp_multiplier, registered.
REQ-008 op_valid  output  1  high while op_a/op_b carry a pair to be multiplied.
REQ-009 product_in  input  32  product from sp_fp_multiplier.
REQ-010 res_valid  output  1  one-cycle pulse: res_* hold a captured result.
REQ-011 res_idx  output  3  pair index of the captured result.
REQ-012 res_data  output  32  captured product.
REQ-013 res_flags  output  3  {nan, inf, zero} classification of res_data.
REQ-014 busy  output  1  high in ISSUE and DRAIN.
REQ-015 done  output  1  one-cycle pulse on the DRAIN to IDLE transition.

Function
REQ-016 The internal ROM SHALL hold rom[0..4] = 0xFFFFFFFF, 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
REQ-017 The FSM SHALL have states IDLE, ISSUE and DRAIN.
REQ-018 IDLE: an edge sampling start=1 SHALL move the FSM to ISSUE with idx=0; start=1 in any other state SHALL be ignored.
REQ-019 ISSUE, pair i: the block SHALL drive op_a=rom[i], op_b=rom[(i+1) mod ROM_DEPTH], op_valid=1 for exactly one cycle per pair, for i = 0..ROM_DEPTH-1 on consecutive cycles with no gaps.
REQ-020 The ROM_DEPTH-1 to 0 wrap SHALL apply to op_b only, so pair 4 = (0xCCDDEEFF, 0xFFFFFFFF).
REQ-021 After the last pair the FSM SHALL enter DRAIN; op_valid SHALL drop to 0 and op_a/op_b SHALL hold their last values.
REQ-022 A valid/index delay pipe of MULT_LATENCY stages SHALL track issued pairs.
REQ-023 For a pair presented in cycle t, product_in SHALL be sampled at the end of cycle t+MULT_LATENCY, with res_valid=1 and res_idx=i in cycle t+MULT_LATENCY+1.
REQ-024 res_flags SHALL be computed from product_in at capture time: nan = exp==0xFF and mant!=0; inf = exp==0xFF and mant==0; zero = exp==0 and mant==0, sign ignored.
REQ-025 res_data, res_idx and res_flags SHALL hold their value between res_valid pulses.
REQ-026 DRAIN SHALL last until the delay pipe is empty; the FSM SHALL then go to IDLE with done=1 for that one cycle.
REQ-027 Total start-to-done SHALL be deterministic: start sampled at edge 0, done high in cycle ROM_DEPTH+MULT_LATENCY+1.
REQ-028 A start present in the same cycle as done SHALL be ignored, because it is sampled in DRAIN.
REQ-029 A start on the first IDLE cycle after done SHALL begin a new run.

Reset
REQ-030 rst_n=0 at any rising edge SHALL force: state=IDLE, idx=0, delay pipe cleared, op_a=op_b=0, op_valid=0, res_valid=0, res_idx=0, res_data=0, res_flags=0, busy=0, done=0.
REQ-031 Reset during ISSUE or DRAIN SHALL abort the run: no res_valid or done pulse for in-flight pairs, even if the multiplier still emits them.
REQ-032 A start held high through reset release SHALL start a run on the first edge with rst_n=1.

Verification
REQ-033 Reset, then start pulse with sp_fp_multiplier attached: the bench SHALL check op pairs 0..4 on five consecutive cycles, then op_valid=0.
REQ-034 Same run: the bench SHALL check these captures in order:
- idx0 → flags nan=1.
- idx1 → 0x04F1F717.
- idx2 → 0x8D80188F.
- idx3 → 0x160537D9.
- idx4 → flags nan=1.
- done in cycle 9.
REQ-035 Bench-driven product_in = 0x7F800000, 0x80000000, 0x00000000: the bench SHALL check flags inf, zero, zero respectively.
REQ-036 rst_n=0 asserted in the cycle pair 2 issues: the bench SHALL check no further res_valid or done, all outputs 0, and a clean full run on the next start.
REQ-037 start held high continuously: the bench SHALL check back-to-back runs separated by exactly one IDLE cycle, and start ignored while busy=1.

Source files
------------

// File: rtl/fp_mult_sequencer_if.sv
// Operand/result bundle between the FP multiply sequencer and its environment.
// The master side is the sequencer; the slave side feeds start and the multiplier product.
interface fp_mult_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_valid;
  logic [31:0] product_in;
  logic        res_valid;
  logic [2:0]  res_idx;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic        busy;
  logic        done;

  modport master (
    input  start, product_in,
    output op_a, op_b, op_valid, res_valid, res_idx, res_data, res_flags, busy, done
  );

  modport slave (
    output start, product_in,
    input  op_a, op_b, op_valid, res_valid, res_idx, res_data, res_flags, busy, done
  );
endinterface

// File: rtl/fp_mult_sequencer.sv
// Streams neighbouring ROM word pairs into an external single-precision multiplier
// and captures each product, with its {nan, inf, zero} class, after a fixed latency.
module fp_mult_sequencer #(
  parameter int ROM_DEPTH    = 5,
  parameter int MULT_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_mult_sequencer_if.master bus
);

  localparam logic [2:0] LAST_IDX = 3'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_op_valid;
  logic        r_res_valid;
  logic [2:0]  r_res_idx;
  logic [31:0] r_res_data;
  logic [2:0]  r_res_flags;
  logic        r_busy;
  logic        r_done;

  logic [MULT_LATENCY-1:0] r_pipe_vld;
  logic [2:0]              r_pipe_idx [MULT_LATENCY];

  logic       w_pipe_empty;
  logic       w_last;
  logic [2:0] w_next_idx;

  function automatic logic [31:0] rom_word(input logic [2:0] i);
    logic [31:0] w;
    case (i)
      3'd0:    w = 32'hFFFF_FFFF;
      3'd1:    w = 32'h0011_2233;
      3'd2:    w = 32'h4455_6677;
      3'd3:    w = 32'h8899_AABB;
      3'd4:    w = 32'hCCDD_EEFF;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Only the B operand wraps back to word 0 after the last ROM entry.
  function automatic logic [2:0] wrap_inc(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] classify(input logic [31:0] p);
    logic [7:0]  e;
    logic [22:0] m;
    e = p[30:23];
    m = p[22:0];
    return {(e == 8'hFF) && (m != '0), (e == 8'hFF) && (m == '0), (e == 8'h00) && (m == '0)};
  endfunction

  assign w_pipe_empty = ~|r_pipe_vld;
  assign w_last       = (r_idx == LAST_IDX);
  assign w_next_idx   = r_idx + 3'd1;

  // NOTE: every register here uses <= so all next-state terms read pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      // NOTE: the delay pipe must be cleared so an aborted run never reports in-flight pairs.
      r_pipe_vld  <= '0;
      for (int k = 0; k < MULT_LATENCY; k++) r_pipe_idx[k] <= '0;
    end else begin
      r_pipe_vld[0] <= r_op_valid;
      r_pipe_idx[0] <= r_idx;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_idx[k] <= r_pipe_idx[k-1];
      end

      r_res_valid <= r_pipe_vld[MULT_LATENCY-1];
      if (r_pipe_vld[MULT_LATENCY-1]) begin
        r_res_data  <= bus.product_in;
        r_res_idx   <= r_pipe_idx[MULT_LATENCY-1];
        r_res_flags <= classify(bus.product_in);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_ISSUE;
            r_idx      <= '0;
            r_op_a     <= rom_word(3'd0);
            r_op_b     <= rom_word(wrap_inc(3'd0));
            r_op_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_last) begin
            r_state    <= ST_DRAIN;
            r_op_valid <= 1'b0;
          end else begin
            r_idx  <= w_next_idx;
            r_op_a <= rom_word(w_next_idx);
            r_op_b <= rom_word(wrap_inc(w_next_idx));
          end
        end
        ST_DRAIN: begin
          // done is raised in the last DRAIN cycle so a coincident start is still ignored.
          if (r_done) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_pipe_empty) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.op_valid  = r_op_valid;
  assign bus.res_valid = r_res_valid;
  assign bus.res_idx   = r_res_idx;
  assign bus.res_data  = r_res_data;
  assign bus.res_flags = r_res_flags;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Bench for fp_mult_sequencer: behavioural multiplier plus a cycle schedule of each run.
// Cycle k of a run is the interval after the k-th edge counted from the edge that samples start.
module tb_fp_mult_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mult_sequencer_if bus ();

  fp_mult_sequencer #(.ROM_DEPTH(5), .MULT_LATENCY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rom_m [5] = '{32'hFFFF_FFFF, 32'h0011_2233, 32'h4455_6677,
                             32'h8899_AABB, 32'hCCDD_EEFF};

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] exp_data;
  logic [2:0]  exp_idx;
  logic [2:0]  exp_flags;

  logic [31:0] ovr_tbl [5];
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  // Stand-in multiplier: hidden bit always set, exponent bias 127, product truncated.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea, eb;
    int          e;
    longint unsigned ma, mb, m;
    logic        s;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    m  = ma * mb;
    e  = int'(ea) + int'(eb) - 127;
    if (m >= (64'd1 << 47)) begin
      e = e + 1;
      m = m >> 24;
    end else begin
      m = m >> 23;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [2:0] tb_flags(input logic [31:0] v);
    int unsigned e, m;
    e = (v >> 23) & 32'd255;
    m = v & 32'h007F_FFFF;
    return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0};
  endfunction

  logic [31:0] mq [3];
  always @(posedge clk) begin
    mq[0] <= fmul(bus.op_a, bus.op_b);
    mq[1] <= mq[0];
    mq[2] <= mq[1];
  end
  assign bus.product_in = ovr_en ? ovr_val : mq[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_res_hold();
    chk("res_idx", 32'(bus.res_idx), 32'(exp_idx));
    chk("res_data", bus.res_data, exp_data);
    chk("res_flags", 32'(bus.res_flags), 32'(exp_flags));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_a"}, bus.op_a, 32'h0);
    chk({tag, "_op_b"}, bus.op_b, 32'h0);
    chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'h0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
    chk({tag, "_res_idx"}, 32'(bus.res_idx), 32'h0);
    chk({tag, "_res_data"}, bus.res_data, 32'h0);
    chk({tag, "_res_flags"}, 32'(bus.res_flags), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
  endtask

  // Entered at a negedge with start already high; returns at the negedge of cycle 10.
  task automatic check_run(input bit hold, input bit use_ovr, input bit spec_vals);
    @(posedge clk);
    for (int k = 0; k <= 10; k++) begin
      int p;
      int i;
      @(negedge clk);
      p = (k > 4) ? 4 : k;
      chk("op_valid", 32'(bus.op_valid), 32'(k <= 4));
      chk("op_a", bus.op_a, rom_m[p]);
      chk("op_b", bus.op_b, rom_m[(p + 1) % 5]);
      chk("busy", 32'(bus.busy), 32'(k <= 9));
      chk("done", 32'(bus.done), 32'(k == 9));
      chk("res_valid", 32'(bus.res_valid), 32'(k >= 4 && k <= 8));
      if (k >= 4 && k <= 8) begin
        i         = k - 4;
        exp_idx   = 3'(i);
        exp_data  = use_ovr ? ovr_tbl[i] : fmul(rom_m[i], rom_m[(i + 1) % 5]);
        exp_flags = tb_flags(exp_data);
      end
      chk_res_hold();
      if (spec_vals) begin
        if (k == 4) chk("idx0_nan", 32'(bus.res_flags[2]), 32'd1);
        if (k == 5) chk("idx1_data", bus.res_data, 32'h04F1_F717);
        if (k == 6) chk("idx2_data", bus.res_data, 32'h8D80_188F);
        if (k == 7) chk("idx3_data", bus.res_data, 32'h1605_37D9);
        if (k == 8) chk("idx4_nan", 32'(bus.res_flags[2]), 32'd1);
      end
      ovr_en = use_ovr && k >= 3 && k <= 7;
      if (ovr_en) ovr_val = ovr_tbl[k - 3];
      if (!hold) bus.start = (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    ovr_en = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    bus.start = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("gap_busy", 32'(bus.busy), 32'h0);
      chk("gap_op_valid", 32'(bus.op_valid), 32'h0);
      chk("gap_res_valid", 32'(bus.res_valid), 32'h0);
      chk_res_hold();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    exp_data  = '0;
    exp_idx   = '0;
    exp_flags = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle_gap(2);

    // Nominal run with the multiplier model attached.
    bus.start = 1'b1;
    check_run(1'b0, 1'b0, 1'b1);
    idle_gap(int'($urandom_range(1, 3)));

    // Directed classification: inf, -0, +0, then two random products.
    ovr_tbl = '{32'h7F80_0000, 32'h8000_0000, 32'h0000_0000, $urandom, $urandom};
    bus.start = 1'b1;
    check_run(1'b0, 1'b1, 1'b0);
    chk("flags_inf_seen", 32'(tb_flags(32'h7F80_0000)), 32'b010);
    idle_gap(int'($urandom_range(1, 3)));

    // Random products, including a NaN with a random non-zero mantissa.
    for (int r = 0; r < 2; r++) begin
      ovr_tbl = '{$urandom, {1'($urandom), 8'hFF, 23'($urandom) | 23'd1}, $urandom,
                  {1'($urandom), 8'h00, 23'($urandom)}, $urandom};
      bus.start = 1'b1;
      check_run(1'b0, 1'b1, 1'b0);
      idle_gap(int'($urandom_range(1, 4)));
    end

    // start held high: runs follow each other with a single IDLE cycle between them.
    bus.start = 1'b1;
    for (int r = 0; r < 3; r++) check_run(1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    idle_gap(2);

    // Reset while pair 2 is on the bus, with start held through the reset release.
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_op_a", bus.op_a, rom_m[2]);
    chk("abort_op_valid", 32'(bus.op_valid), 32'd1);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    exp_data  = '0;
    exp_idx   = '0;
    exp_flags = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk_all_zero("abort");
    end
    rst_n = 1'b1;
    check_run(1'b0, 1'b0, 1'b1);
    idle_gap(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
